// File: rtl/whack_pkg.sv
// Shared types and defaults for the whack-a-mole field sequencing logic.
package whack_pkg;

   typedef enum logic [1:0] {IDLE, GAP, UP} state_e;

   typedef struct packed {
      logic hit;
      logic miss;
      logic wrong;
   } mole_evt_t;

   localparam int         NUM_MOLES_DEF = 5;
   localparam logic [2:0] NO_POS        = 3'd7;

   // Fibonacci taps 8,6,5,4 as bit positions 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   localparam int GAP_TICKS_DEF = 300;
   localparam int UP_BASE_DEF   = 1000;
   localparam int UP_STEP_DEF   = 50;
   localparam int UP_MIN_DEF    = 300;

   function automatic logic lfsr_fb(input logic [7:0] v);
      return ^(v & LFSR_TAPS);
   endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; steps every clock so press timing stirs the sequence.
module mole_lfsr
   import whack_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   output logic [7:0] value
);

   logic [7:0] lfsr_q, lfsr_d;

   always_comb lfsr_d = {lfsr_q[6:0], lfsr_fb(lfsr_q)};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) lfsr_q <= SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign value = lfsr_q;

endmodule

// File: rtl/mole_scheduler.sv
// Mole field sequencer: dark gap, random lit mole, hit / timeout / wrong-press detection,
// with an up-window that shrinks as score rises.
module mole_scheduler
   import whack_pkg::*;
#(
   parameter int         NUM_MOLES = NUM_MOLES_DEF,
   parameter int         SCORE_W   = 6,
   parameter int         CNT_W     = 12,
   parameter int         GAP_TICKS = GAP_TICKS_DEF,
   parameter int         UP_BASE   = UP_BASE_DEF,
   parameter int         UP_STEP   = UP_STEP_DEF,
   parameter int         UP_MIN    = UP_MIN_DEF,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 tick,
   input  logic [SCORE_W-1:0]   score,
   input  logic [NUM_MOLES-1:0] mole_button,
   output logic [NUM_MOLES-1:0] mole_led,
   output logic [2:0]           active_pos,
   output logic                 hit_pulse,
   output logic                 miss_pulse,
   output logic                 wrong_pulse
);

   localparam int UW = CNT_W + SCORE_W;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           prev_q, prev_d;
   logic [2:0]           pos_q, pos_d;
   logic [NUM_MOLES-1:0] led_q, led_d;
   mole_evt_t            evt_q, evt_d;

   logic [7:0]           lfsr;
   logic [2:0]           cand, pick;
   logic [UW-1:0]        dec, base;
   logic [CNT_W-1:0]     up_ticks;
   logic                 hit, wrong, last_tick;

   mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clock (clock),
      .reset (reset),
      .value (lfsr)
   );

   // Wide arithmetic so a large score underflows visibly instead of wrapping into a long window
   always_comb begin
      dec  = UW'(score >> 2) * UW'(UP_STEP);
      base = UW'(UP_BASE);
      if (dec > base || (base - dec) < UW'(UP_MIN)) up_ticks = CNT_W'(UP_MIN);
      else                                           up_ticks = CNT_W'(base - dec);
   end

   always_comb begin
      cand = 3'(lfsr % 8'(NUM_MOLES));
      if (cand == prev_q) pick = (cand == 3'(NUM_MOLES - 1)) ? 3'd0 : cand + 3'd1;
      else                pick = cand;
   end

   assign hit       = |(mole_button & led_q);
   assign wrong     = |(mole_button & ~led_q);
   assign last_tick = tick && (cnt_q <= CNT_W'(1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prev_d  = prev_q;
      pos_d   = pos_q;
      led_d   = led_q;
      evt_d   = '0;
      if (!enable) begin
         state_d = IDLE;
         led_d   = '0;
         pos_d   = NO_POS;
      end else begin
         case (state_q)
            IDLE: begin
               led_d   = '0;
               pos_d   = NO_POS;
               cnt_d   = CNT_W'(GAP_TICKS);
               state_d = GAP;
            end
            GAP: begin
               if (last_tick) begin
                  led_d   = NUM_MOLES'(1) << pick;
                  pos_d   = pick;
                  prev_d  = pick;
                  cnt_d   = up_ticks;
                  state_d = UP;
               end else if (tick) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            UP: begin
               if (hit || last_tick) begin
                  evt_d.hit  = hit;
                  evt_d.miss = !hit;
                  led_d      = '0;
                  pos_d      = NO_POS;
                  cnt_d      = CNT_W'(GAP_TICKS);
                  state_d    = GAP;
               end else begin
                  evt_d.wrong = wrong;
                  if (tick) cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prev_q  <= NO_POS;
         pos_q   <= NO_POS;
         led_q   <= '0;
         evt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prev_q  <= prev_d;
         pos_q   <= pos_d;
         led_q   <= led_d;
         evt_q   <= evt_d;
      end
   end

   assign mole_led    = led_q;
   assign active_pos  = pos_q;
   assign hit_pulse   = evt_q.hit;
   assign miss_pulse  = evt_q.miss;
   assign wrong_pulse = evt_q.wrong;

endmodule

// File: tb/tb_mole_scheduler.sv
// Randomized bench for mole_scheduler against a cycle-level behavioural model of the game rules.
module tb_mole_scheduler;

   localparam int GAP = 3, BASE = 5, STEP = 1, UMIN = 2, N = 5;
   localparam int LIT = 0, MISS = 1;

   logic       clock, reset, enable, tick;
   logic [5:0] score;
   logic [4:0] mole_button, mole_led;
   logic [2:0] active_pos;
   logic       hit_pulse, miss_pulse, wrong_pulse;

   mole_scheduler #(
      .NUM_MOLES(N), .SCORE_W(6), .CNT_W(12), .GAP_TICKS(GAP),
      .UP_BASE(BASE), .UP_STEP(STEP), .UP_MIN(UMIN), .LFSR_SEED(8'hA5)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .tick(tick), .score(score),
      .mole_button(mole_button), .mole_led(mole_led), .active_pos(active_pos),
      .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .wrong_pulse(wrong_pulse)
   );

   initial clock = 0;
   always #5 clock = ~clock;

   int n_chk = 0, n_err = 0;
   int cycle_no = 0, moles = 0, last_pos = 7;
   logic t_edge;
   bit launched;
   bit seen [N];

   // model: 0 idle, 1 dark gap, 2 mole up
   int m_state, m_cnt, m_prev, m_pos;
   logic [4:0] m_led;
   logic [7:0] m_lfsr;
   bit m_hit, m_miss, m_wrong;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, expv, $time);
      end
   endtask

   function automatic int up_len(input int s);
      int t = BASE - (s / 4) * STEP;
      return (t < UMIN) ? UMIN : t;
   endfunction

   task automatic model_rst();
      m_state = 0; m_cnt = 0; m_prev = 7; m_pos = 7; m_led = '0;
      m_lfsr = 8'hA5; m_hit = 0; m_miss = 0; m_wrong = 0;
   endtask

   task automatic model_step();
      logic [7:0] nl;
      int p;
      if (reset) begin model_rst(); return; end
      nl = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      m_hit = 0; m_miss = 0; m_wrong = 0;
      if (!enable) begin
         m_state = 0; m_led = '0; m_pos = 7;
      end else if (m_state == 0) begin
         m_cnt = GAP; m_state = 1;
      end else if (m_state == 1) begin
         if (tick) begin
            if (m_cnt == 1) begin
               p = m_lfsr % N;
               if (p == m_prev) p = (p + 1) % N;
               m_led = '0; m_led[p] = 1'b1;
               m_pos = p; m_prev = p; m_cnt = up_len(int'(score)); m_state = 2;
               launched = 1;
            end else m_cnt--;
         end
      end else begin
         if ((mole_button & m_led) != 0) begin
            m_hit = 1; m_led = '0; m_pos = 7; m_cnt = GAP; m_state = 1;
         end else if (tick && m_cnt == 1) begin
            m_miss = 1; m_led = '0; m_pos = 7; m_cnt = GAP; m_state = 1;
         end else begin
            if ((mole_button & ~m_led) != 0) m_wrong = 1;
            if (tick) m_cnt--;
         end
      end
      m_lfsr = nl;
   endtask

   task automatic cyc();
      tick = cycle_no[0];
      t_edge = tick;
      cycle_no++;
      launched = 0;
      model_step();
      @(posedge clock); #1;
      chk("led", mole_led, m_led);
      chk("pos", active_pos, m_pos);
      chk("hit", hit_pulse, m_hit);
      chk("miss", miss_pulse, m_miss);
      chk("wrong", wrong_pulse, m_wrong);
      if (launched) begin
         moles++;
         chk("onehot", $onehot(mole_led), 1);
         chk("norepeat", active_pos != 3'(last_pos), 1);
         last_pos = active_pos;
         if (active_pos < N) seen[active_pos] = 1;
      end
      mole_button = '0;
   endtask

   task automatic run_until(input int what, input string tag, output int ticks);
      bit done = 0;
      ticks = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         cyc();
         ticks += int'(t_edge);
         done = (what == LIT) ? (mole_led != 0) : (miss_pulse == 1'b1);
      end
      if (!done) chk({"wait_", tag}, 0, 1);
   endtask

   initial begin
      int t, w, nseen, cyc_budget;
      logic [4:0] led_sv;
      logic [2:0] pos_sv;
      bit done;

      reset = 1; enable = 0; tick = 0; score = 0; mole_button = '0;
      model_rst();
      #3;
      chk("rst_led", mole_led, 0);
      chk("rst_pos", active_pos, 7);
      chk("rst_pulses", {hit_pulse, miss_pulse, wrong_pulse}, 0);
      cyc(); cyc();
      reset = 0;

      // 1: first mole after 3 ticks, miss after 5 ticks
      while (cycle_no[0] != 0) cyc();
      enable = 1;
      run_until(LIT, "first_lit", t);
      chk("gap_ticks", t, GAP);
      run_until(MISS, "first_miss", t);
      chk("miss_ticks", t, 5);
      chk("miss_led_off", mole_led, 0);

      // 2: hit, then next mole at a different position
      run_until(LIT, "lit2", t);
      pos_sv = active_pos;
      mole_button = m_led;
      cyc();
      chk("hit_pulse", hit_pulse, 1);
      chk("hit_led_off", mole_led, 0);
      run_until(LIT, "lit_after_hit", t);
      chk("gap_after_hit", t, GAP);
      chk("new_pos", active_pos != pos_sv, 1);

      // 3: wrong press, then hit + wrong on the timeout tick
      led_sv = mole_led;
      w = (m_pos + 1 + int'($urandom_range(0, 3))) % N;
      mole_button = 5'(1 << w);
      cyc();
      chk("wrong_pulse", wrong_pulse, 1);
      chk("wrong_led_kept", mole_led, led_sv);
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         done = (m_state == 2 && m_cnt == 1 && cycle_no[0] == 1);
         if (!done) cyc();
      end
      if (!done) chk("wait_last_tick", 0, 1);
      mole_button = m_led | 5'(1 << w);
      cyc();
      chk("combo_hit", hit_pulse, 1);
      chk("combo_nomiss", miss_pulse, 0);
      chk("combo_nowrong", wrong_pulse, 0);

      // 4: score-scaled windows; score moves after launch must not matter
      score = 12;
      run_until(LIT, "lit_s12", t);
      score = 6'($urandom_range(0, 63));
      run_until(MISS, "miss_s12", t);
      chk("win_s12", t, 2);
      score = 63;
      run_until(LIT, "lit_s63", t);
      score = 0;
      run_until(MISS, "miss_s63", t);
      chk("win_s63", t, 2);
      score = 4;
      run_until(LIT, "lit_s4", t);
      run_until(MISS, "miss_s4", t);
      chk("win_s4", t, 4);

      // 5: enable drop mid-UP, then fresh gap on re-enable
      run_until(LIT, "lit_en", t);
      enable = 0;
      cyc();
      chk("dis_led", mole_led, 0);
      chk("dis_pos", active_pos, 7);
      chk("dis_pulses", {hit_pulse, miss_pulse}, 0);
      cyc();
      while (cycle_no[0] != 0) cyc();
      enable = 1;
      run_until(LIT, "lit_reen", t);
      chk("reen_gap", t, GAP);

      // 6: async reset between edges right after a hit
      mole_button = m_led;
      cyc();
      #2 reset = 1;
      #1;
      chk("arst_hit", hit_pulse, 0);
      chk("arst_led", mole_led, 0);
      chk("arst_pos", active_pos, 7);
      model_rst();
      last_pos = 7;
      cyc();
      reset = 0;

      moles = 0;
      for (int i = 0; i < N; i++) seen[i] = 0;
      cyc_budget = 0;
      while (moles < 200 && cyc_budget < 20000) begin
         enable = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 15) == 0) score = 6'($urandom_range(0, 63));
         case ($urandom_range(0, 9))
            0: mole_button = m_led;
            1: mole_button = 5'($urandom_range(0, 31));
            default: mole_button = '0;
         endcase
         cyc();
         cyc_budget++;
      end
      chk("moles_200", moles >= 200, 1);
      nseen = 0;
      for (int i = 0; i < N; i++) nseen += int'(seen[i]);
      chk("all_pos", nseen, N);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Sequences the mole field during an active game.
- Chooses a pseudo-random mole, holds it lit for an up-window, and detects a hit, a timeout or a wrong-button press.
- Shortens the up-window as score rises.
- Sits between the game FSM (enable, score), the debounced mole buttons and the mole LEDs. It replaces direct LED drive from the mole generator.

Parameters:
- NUM_MOLES, 5: number of mole positions/buttons.
- SCORE_W, 6: score input width.
- CNT_W, 12: tick counter width.
- GAP_TICKS, 300: dark ticks between moles.
- UP_BASE, 1000: up-window ticks at score 0.
- UP_STEP, 50: up-window reduction per 4 points of score.
- UP_MIN, 300: up-window floor.
- LFSR_SEED, 8'hA5: LFSR reset value; must be non-zero.

Ports:
- clock  in  1: system clock, 100 MHz.
- reset  in  1: asynchronous, active-high reset.
- enable  in  1: game active, level.
- tick  in  1: one-cycle timebase pulse, 1 kHz nominal.
- score  in  SCORE_W: current score, sampled at mole launch.
- mole_button  in  NUM_MOLES: debounced one-cycle press pulses.
- mole_led  out  NUM_MOLES: one-hot active mole, or all zero.
- active_pos  out  3: index of lit mole; 7 when none.
- hit_pulse  out  1: one cycle, correct mole hit.
- miss_pulse  out  1: one cycle, up-window expired.
- wrong_pulse  out  1: one cycle, press on a dark position while a mole is up.

Behaviour:
- Reset values: state IDLE, mole_led 0, active_pos 7, all pulses 0, lfsr LFSR_SEED, prev_pos 7, counter 0.
- All outputs are registered.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clock when not in reset, regardless of state, so human timing adds entropy.
- Position pick:
  - cand = lfsr mod NUM_MOLES.
  - If cand == prev_pos, use (cand+1) mod NUM_MOLES. The same mole never lights twice in a row.
- Up-window:
  - up_ticks = UP_BASE − (score>>2)·UP_STEP, computed in CNT_W+SCORE_W bits.
  - Saturates to UP_MIN if the result is below UP_MIN or the subtraction underflows.
  - Score is sampled once at launch; score changes during UP do not affect the current window.
- State IDLE: LEDs off. When enable=1, load counter = GAP_TICKS and go to GAP next cycle.
- State GAP:
  - Counter decrements on tick.
  - On the tick that takes the counter from 1 to 0, in the same edge: mole_led ← onehot(pos), active_pos ← pos, prev_pos ← pos, counter ← up_ticks, go to UP.
  - Buttons are ignored in GAP.
- State UP, evaluated each cycle in priority order:
  1. Hit: (mole_button & mole_led) ≠ 0. hit_pulse=1 next cycle, LEDs off, active_pos 7, counter ← GAP_TICKS, go to GAP. A hit wins over a simultaneous timeout tick and over simultaneous wrong presses (no wrong_pulse).
  2. Timeout: tick with counter==1. miss_pulse=1, LEDs off, counter ← GAP_TICKS, go to GAP.
  3. Wrong press: (mole_button & ~mole_led) ≠ 0. wrong_pulse=1 for one cycle; stay in UP and the mole stays lit.
- Pulses are high exactly one cycle: the cycle after the deciding edge.
- enable falling in any state: next edge goes to IDLE, mole_led 0, active_pos 7, no hit/miss pulse generated. prev_pos is retained.
- enable re-asserted: a fresh GAP_TICKS gap runs before the first mole.
- Reset mid-operation: immediate asynchronous clear to the reset values above; LFSR returns to the seed.
- tick and enable fall on the same cycle: enable wins (go to IDLE).

Decomposition:
- Package whack_pkg:
  - state enum {IDLE, GAP, UP}.
  - NUM_MOLES_DEF=5.
  - NO_POS=3'd7.
  - LFSR taps constant.
  - Timing defaults in ticks.
- Sub-module mole_lfsr: 8-bit Fibonacci LFSR.
  - Ports: clock, reset, seed param, 8-bit value out.
  - Shared with the existing mole generator.
- Everything else stays in mole_scheduler: FSM, counter, pick logic, up-time arithmetic.

Test Plan:
All scenarios use GAP_TICKS=3, UP_BASE=5, UP_STEP=1, UP_MIN=2, with tick every 2nd cycle.
1. Reset, enable=1, score=0 → mole_led 0 until the 3rd tick. A single one-hot LED lights on that edge, with active_pos equal to its index. No press → miss_pulse exactly one cycle after the 5th tick; LEDs off on the same edge.
2. While UP, pulse the button matching mole_led → hit_pulse=1 for one cycle the next cycle, LEDs off, next mole after 3 ticks at a different position.
3. While UP, press a wrong button → wrong_pulse one cycle, LED unchanged. Then press the correct button and the wrong button together on the timeout tick → only hit_pulse.
4. score=12 → up-window 5−3=2 ticks. score=63 → saturates to UP_MIN=2. Check miss timing in both cases.
5. Deassert enable mid-UP → next cycle LEDs 0, active_pos 7, no pulses. Reassert enable → first mole after 3 ticks.
6. Assert reset asynchronously between clock edges mid-GAP → outputs clear immediately. Run 200 moles and check every mole is one-hot, never repeats its predecessor, and all 5 positions occur.
